serdesphy_tx_serializer: RTL

SERDESPHY_TX_SERIALIZER -- requirements
Module: serdesphy_tx_serializer

---
 rtl/serdesphy_tx_serializer.sv | 106 ++++++++++
 1 files changed

// File: rtl/serdesphy_tx_serializer.sv
// serdesphy_tx_serializer: 4-entry nibble FIFO feeding an MSB-first serializer
// with IDLE fill, PRBS7 test pattern and differential electrical-idle output.
module serdesphy_tx_serializer #(
    parameter logic [3:0] IDLE_NIBBLE = 4'hA,
    parameter logic [6:0] PRBS_SEED   = 7'h7F
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_en,
    input  logic       test_mode,
    input  logic [3:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ovf_clr,
    output logic       txp,
    output logic       txn,
    output logic [2:0] fifo_cnt,
    output logic       ovf,
    output logic [1:0] mode
);
    typedef enum logic [1:0] {OFF = 2'd0, IDLE = 2'd1, DATA = 2'd2, PRBS = 2'd3} mode_t;

    mode_t       state, state_nxt;
    logic [3:0]  mem [4];
    logic [1:0]  wr_ptr, rd_ptr, bit_cnt, bit_cnt_nxt;
    logic [2:0]  cnt;
    logic [3:0]  sreg, sreg_nxt;
    logic [6:0]  lfsr, lfsr_nxt;
    logic [10:0] prbs;
    logic        boundary, push, pop;

    // Four LFSR steps: returns {nibble (first bit in MSB), advanced state}.
    function automatic logic [10:0] prbs4(input logic [6:0] s0);
        logic [6:0] s;
        logic [3:0] n;
        s = s0;
        n = '0;
        for (int i = 0; i < 4; i++) begin
            n = {n[2:0], s[6]};
            s = {s[5:0], s[6] ^ s[5]};
        end
        return {n, s};
    endfunction

    assign tx_ready = cnt != 3'd4;
    assign push     = tx_valid && tx_ready;
    assign boundary = tx_en && bit_cnt == 2'd3;
    assign pop      = boundary && !test_mode && cnt != 3'd0;
    assign prbs     = prbs4(state == PRBS ? lfsr : PRBS_SEED);
    assign fifo_cnt = cnt;
    assign mode     = state;
    assign txp      = state != OFF && sreg[3];
    assign txn      = state != OFF && !sreg[3];

    always_comb begin
        state_nxt   = state;
        sreg_nxt    = {sreg[2:0], 1'b0};
        bit_cnt_nxt = bit_cnt + 2'd1;
        lfsr_nxt    = lfsr;
        if (!tx_en) begin
            state_nxt   = OFF;
            sreg_nxt    = '0;
            bit_cnt_nxt = 2'd3;
        end else if (boundary) begin
            bit_cnt_nxt = '0;
            if (test_mode) begin
                state_nxt = PRBS;
                sreg_nxt  = prbs[10:7];
                lfsr_nxt  = prbs[6:0];
            end else if (cnt != 3'd0) begin
                state_nxt = DATA;
                sreg_nxt  = mem[rd_ptr];
            end else begin
                state_nxt = IDLE;
                sreg_nxt  = IDLE_NIBBLE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= OFF;
            sreg    <= '0;
            bit_cnt <= 2'd3;
            lfsr    <= PRBS_SEED;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            cnt     <= '0;
            ovf     <= 1'b0;
        end else begin
            state   <= state_nxt;
            sreg    <= sreg_nxt;
            bit_cnt <= bit_cnt_nxt;
            lfsr    <= lfsr_nxt;
            wr_ptr  <= wr_ptr + 2'(push);
            rd_ptr  <= rd_ptr + 2'(pop);
            cnt     <= cnt + 3'(push) - 3'(pop);
            ovf     <= (tx_valid && !tx_ready) ? 1'b1 : ovf_clr ? 1'b0 : ovf;
        end
    end

    // Storage needs no reset: an empty FIFO is never read.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= tx_data;
    end
endmodule
